lcd_bus_sequencer: RTL and testbench

- Sequences the 16-bit 8080-style parallel LCD write bus (cs_n, d_c_n, wr_n, data) and shares it between two requesters.
- Requester 1 is a CPU command/parameter port. Requester 2 is a DMA pixel stream that runs counted bursts.
- Generates write strobes with programmable low/high widths and raises an end-of-transaction interrupt when a pixel burst completes.
- Sits between the Avalon-side register/DMA logic and the LCD pins.

---
 rtl/lcd_bus_sequencer_if.sv | 32 +++
 rtl/lcd_bus_sequencer.sv | 132 +++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_sequencer_if.sv
// rtl/lcd_bus_sequencer_if.sv - requester handshakes, interrupt and LCD pin bundle for the bus sequencer
interface lcd_bus_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 20
);
  logic              cmd_valid;
  logic              cmd_dc;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              pix_start;
  logic [CNT_W-1:0]  pix_count;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              irq_clr;
  logic              eot_irq;
  logic              busy;
  logic              lcd_cs_n;
  logic              lcd_d_c_n;
  logic              lcd_wr_n;
  logic [DATA_W-1:0] lcd_data;

  modport slave (
    input  cmd_valid, cmd_dc, cmd_data, pix_start, pix_count, pix_valid, pix_data, irq_clr,
    output cmd_ready, pix_ready, eot_irq, busy, lcd_cs_n, lcd_d_c_n, lcd_wr_n, lcd_data
  );

  modport master (
    output cmd_valid, cmd_dc, cmd_data, pix_start, pix_count, pix_valid, pix_data, irq_clr,
    input  cmd_ready, pix_ready, eot_irq, busy, lcd_cs_n, lcd_d_c_n, lcd_wr_n, lcd_data
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - 8080-style LCD write sequencer shared by CPU commands and DMA pixel bursts
module lcd_bus_sequencer #(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 20,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_bus_sequencer_if.slave bus
);

  localparam int MAXC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, WR_LOW, WR_HIGH} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              burst_active;
  logic [CNT_W-1:0]  remaining;
  logic              eot_q;
  logic              dc_q;
  logic [DATA_W-1:0] data_q;

  logic idle;
  logic cmd_acc, pix_acc;
  logic start_ok, start_zero;
  logic word_done, burst_done;

  // Ready is gated by reset so nothing is handshaken while the block is held in reset
  assign idle          = (state == IDLE);
  assign bus.cmd_ready = reset_n & idle & ~burst_active;
  assign bus.pix_ready = reset_n & idle & burst_active & (remaining != '0);
  assign cmd_acc       = bus.cmd_valid & bus.cmd_ready;
  assign pix_acc       = bus.pix_valid & bus.pix_ready;

  // A start pulse only counts when the bus is idle, unowned, and no command wins the same cycle
  assign start_ok      = bus.pix_start & idle & ~burst_active & ~cmd_acc;
  assign start_zero    = start_ok & (bus.pix_count == '0);
  assign burst_done    = word_done & burst_active & (remaining == '0);

  // Next-state logic: one strobe per accepted word, low phase then high phase
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_acc || pix_acc) begin
          state_n = WR_LOW;
          cnt_n   = '0;
        end
      end
      WR_LOW: begin
        if (cnt == CW'(WR_LOW_CYC - 1)) begin
          state_n = WR_HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WR_HIGH: begin
        if (cnt == CW'(WR_HIGH_CYC - 1)) begin
          state_n   = IDLE;
          cnt_n     = '0;
          word_done = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Output latches, burst bookkeeping and the sticky end-of-transaction flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q       <= '0;
      dc_q         <= 1'b1;
      burst_active <= 1'b0;
      remaining    <= '0;
      eot_q        <= 1'b0;
    end else begin
      if (cmd_acc) begin
        data_q <= bus.cmd_data;
        dc_q   <= bus.cmd_dc;
      end else if (pix_acc) begin
        data_q <= bus.pix_data;
        dc_q   <= 1'b1;
      end

      if (start_ok && !start_zero)
        remaining <= bus.pix_count;
      else if (pix_acc)
        remaining <= remaining - CNT_W'(1);

      if (start_ok && !start_zero)
        burst_active <= 1'b1;
      else if (burst_done)
        burst_active <= 1'b0;

      // Setting wins over a coincident clear so a completion is never lost
      if (start_zero || burst_done)
        eot_q <= 1'b1;
      else if (bus.irq_clr)
        eot_q <= 1'b0;
    end
  end

  assign bus.lcd_wr_n  = (state != WR_LOW);
  assign bus.lcd_cs_n  = ~(~idle | burst_active);
  assign bus.busy      = ~idle | burst_active;
  assign bus.lcd_data  = data_q;
  assign bus.lcd_d_c_n = dc_q;
  assign bus.eot_irq   = eot_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - self-checking bench for lcd_bus_sequencer
module tb_lcd_bus_sequencer;

  localparam int DW = 16;
  localparam int CW = 20;
  localparam int L  = 2;
  localparam int H  = 2;
  localparam int P  = 1 + L + H;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  lcd_bus_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  lcd_bus_sequencer #(
    .DATA_W(DW), .CNT_W(CW), .WR_LOW_CYC(L), .WR_HIGH_CYC(H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus writes in issue order: {d_c_n, data}
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  bit          mon_en;
  logic        prev_wr = 1'b1;
  int          low_len;
  int          writes_seen;

  // Bus monitor: every completed strobe must match the next expected word and have the right width
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_wr = 1'b1;
      low_len = 0;
    end else begin
      if (bus.lcd_wr_n === 1'b0) begin
        low_len++;
        total++;
        if (bus.lcd_cs_n !== 1'b0) begin
          bad++;
          $display("FAIL cs_during_wr got=%b want=0", bus.lcd_cs_n);
        end
      end else if (prev_wr === 1'b0) begin
        total++;
        if (low_len != L) begin
          bad++;
          $display("FAIL wr_low_width got=%0d want=%0d", low_len, L);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got=%b_%h want=none", bus.lcd_d_c_n, bus.lcd_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.lcd_d_c_n, bus.lcd_data} !== mon_e) begin
            bad++;
            $display("FAIL write_word got=%b_%h want=%b_%h", bus.lcd_d_c_n, bus.lcd_data, mon_e[DW], mon_e[DW-1:0]);
          end
        end
        low_len = 0;
        writes_seen++;
      end
      prev_wr = bus.lcd_wr_n;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (bus.busy !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 100) begin
      bad++;
      $display("FAIL wait_idle got=busy want=idle");
    end
  endtask

  task automatic send_cmd(input logic dc, input logic [DW-1:0] d);
    int g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_dc    = dc;
    bus.cmd_data  = d;
    while (bus.cmd_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 100) begin
      bad++;
      $display("FAIL cmd_handshake got=timeout want=accept");
    end else begin
      exp_q.push_back({dc, d});
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'($urandom); bus.cmd_dc    = 1'($urandom);
      bus.cmd_data  = DW'($urandom); bus.pix_start = 1'($urandom);
      bus.pix_count = CW'($urandom); bus.pix_valid = 1'($urandom);
      bus.pix_data  = DW'($urandom); bus.irq_clr   = 1'($urandom);
      @(negedge clk);
      total++;
      if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_d_c_n, bus.lcd_data, bus.cmd_ready, bus.pix_ready, bus.eot_irq, bus.busy}
          !== {1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_vals cyc=%0d got cs/wr/dc/data/cr/pr/eot/busy=%b%b%b_%h_%b%b%b%b want 111_0000_0000",
                 i, bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_d_c_n, bus.lcd_data, bus.cmd_ready, bus.pix_ready, bus.eot_irq, bus.busy);
      end
    end
    bus.cmd_valid = 0; bus.cmd_dc = 0; bus.cmd_data = '0; bus.pix_start = 0;
    bus.pix_count = '0; bus.pix_valid = 0; bus.pix_data = '0; bus.irq_clr = 0;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.pix_ready} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset_ready got=%b%b want=10", bus.cmd_ready, bus.pix_ready);
    end
  endtask

  task automatic test_single_cmd();
    logic exp_wr, exp_cs, exp_rdy;
    exp_q.push_back({1'b0, 16'h002C});
    bus.cmd_valid = 1'b1; bus.cmd_dc = 1'b0; bus.cmd_data = 16'h002C;
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got=%b want=1", bus.cmd_ready);
    end
    for (int k = 1; k <= L + H + 1; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      exp_wr  = (k > L);
      exp_cs  = (k > L + H);
      exp_rdy = (k == L + H + 1);
      total++;
      if ({bus.lcd_wr_n, bus.lcd_cs_n, bus.lcd_d_c_n, bus.lcd_data, bus.cmd_ready} !==
          {exp_wr, exp_cs, 1'b0, 16'h002C, exp_rdy}) begin
        bad++;
        $display("FAIL single_cmd T+%0d got wr/cs/dc/data/rdy=%b%b%b_%h_%b want %b%b0_002c_%b",
                 k, bus.lcd_wr_n, bus.lcd_cs_n, bus.lcd_d_c_n, bus.lcd_data, bus.cmd_ready, exp_wr, exp_cs, exp_rdy);
      end
    end
  endtask

  // Burst of 3 with held valid, a redundant start, a queued command and a clear coincident with completion
  task automatic test_burst();
    logic [DW-1:0] words [0:2];
    int   idx, s, w0;
    bit   acc_pend;
    logic exp_wr, exp_cs, exp_eot;
    words[0] = 16'hF800; words[1] = 16'h07E0; words[2] = 16'h001F;
    idx = 0; acc_pend = 0; s = 2 + 3 * P; w0 = writes_seen;
    for (int i = 0; i <= 4 * P + 2; i++) begin
      if (i > 0) begin
        exp_wr = 1'b1;
        for (int k = 0; k < 4; k++)
          if (i >= 2 + k * P && i <= 1 + k * P + L) exp_wr = 1'b0;
        exp_cs  = !((i >= 1 && i <= 3 * P) || (i >= s && i < s + L + H));
        exp_eot = (i >= 3 * P + 1);
        total++;
        if ({bus.lcd_wr_n, bus.lcd_cs_n, bus.eot_irq, bus.busy} !== {exp_wr, exp_cs, exp_eot, !exp_cs}) begin
          bad++;
          $display("FAIL burst_bus cyc=%0d got wr/cs/eot/busy=%b%b%b%b want %b%b%b%b", i,
                   bus.lcd_wr_n, bus.lcd_cs_n, bus.eot_irq, bus.busy, exp_wr, exp_cs, exp_eot, !exp_cs);
        end
        if (i >= 2) begin
          total++;
          if (bus.lcd_d_c_n !== (i < s)) begin
            bad++;
            $display("FAIL burst_dc cyc=%0d got=%b want=%b", i, bus.lcd_d_c_n, (i < s));
          end
        end
        if (i <= 3 * P + 1) begin
          total++;
          if (bus.cmd_ready !== (i == 3 * P + 1)) begin
            bad++;
            $display("FAIL burst_cmd_ready cyc=%0d got=%b want=%b", i, bus.cmd_ready, (i == 3 * P + 1));
          end
        end
      end
      if (acc_pend) idx++;
      if (i == 0) begin
        bus.pix_start = 1'b1; bus.pix_count = CW'(3); bus.pix_valid = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, words[k]});
      end
      if (i == 1) bus.pix_start = 1'b0;
      if (i == 4) begin
        bus.cmd_valid = 1'b1; bus.cmd_dc = 1'b0; bus.cmd_data = 16'h1234;
        exp_q.push_back({1'b0, 16'h1234});
      end
      if (i == 1 + P) begin
        bus.pix_start = 1'b1; bus.pix_count = CW'(7);
      end
      if (i == 2 + P) bus.pix_start = 1'b0;
      if (i == 3 * P) bus.irq_clr = 1'b1;
      if (i == 3 * P + 1) bus.irq_clr = 1'b0;
      if (i == 3 * P + 2) bus.cmd_valid = 1'b0;
      bus.pix_data = words[(idx > 2) ? 2 : idx];
      acc_pend = bus.pix_valid && bus.pix_ready;
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    total++;
    if (bus.eot_irq !== 1'b1) begin
      bad++;
      $display("FAIL eot_hold got=%b want=1", bus.eot_irq);
    end
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
    total++;
    if (bus.eot_irq !== 1'b0) begin
      bad++;
      $display("FAIL eot_clear got=%b want=0", bus.eot_irq);
    end
    total++;
    if (writes_seen - w0 != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL burst_write_count got=%0d pending=%0d want=4 pending=0", writes_seen - w0, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    bus.pix_start = 1'b1; bus.pix_count = '0;
    @(negedge clk);
    bus.pix_start = 1'b0;
    total++;
    if ({bus.eot_irq, bus.busy, bus.lcd_cs_n, bus.pix_ready, bus.cmd_ready} !== 5'b10101) begin
      bad++;
      $display("FAIL zero_len got eot/busy/cs/pr/cr=%b%b%b%b%b want 10101",
               bus.eot_irq, bus.busy, bus.lcd_cs_n, bus.pix_ready, bus.cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({bus.lcd_wr_n, bus.busy} !== 2'b10) begin
        bad++;
        $display("FAIL zero_len_quiet cyc=%0d got wr/busy=%b%b want 10", i, bus.lcd_wr_n, bus.busy);
      end
    end
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
  endtask

  task automatic test_random();
    int cnt, idx, guard;
    for (int op = 0; op < 30; op++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_cmd(1'($urandom), DW'($urandom));
      end else begin
        wait_idle();
        cnt = $urandom_range(0, 4);
        bus.pix_start = 1'b1; bus.pix_count = CW'(cnt);
        @(negedge clk);
        bus.pix_start = 1'b0;
        idx = 0; guard = 0;
        while (idx < cnt && guard < 200) begin
          bus.pix_data  = DW'($urandom);
          bus.pix_valid = 1'($urandom);
          if (bus.pix_valid && bus.pix_ready) begin
            exp_q.push_back({1'b1, bus.pix_data});
            idx++;
          end
          @(negedge clk);
          guard++;
        end
        bus.pix_valid = 1'b0;
        total++;
        if (idx != cnt) begin
          bad++;
          $display("FAIL rand_pix_accept got=%0d want=%0d", idx, cnt);
        end
        wait_idle();
        total++;
        if (bus.eot_irq !== 1'b1) begin
          bad++;
          $display("FAIL rand_eot len=%0d got=%b want=1", cnt, bus.eot_irq);
        end
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    mon_en = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_dc = 1'b1; bus.cmd_data = 16'hABCD;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    total++;
    if (bus.lcd_wr_n !== 1'b0) begin
      bad++;
      $display("FAIL mid_wr_low got=%b want=0", bus.lcd_wr_n);
    end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.lcd_wr_n, bus.lcd_cs_n, bus.busy, bus.lcd_d_c_n, bus.lcd_data, bus.cmd_ready} !==
        {1'b1, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got wr/cs/busy/dc/data/cr=%b%b%b%b_%h_%b want 1101_0000_0",
               bus.lcd_wr_n, bus.lcd_cs_n, bus.busy, bus.lcd_d_c_n, bus.lcd_data, bus.cmd_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.lcd_wr_n} !== 2'b11) begin
      bad++;
      $display("FAIL mid_recover got cr/wr=%b%b want 11", bus.cmd_ready, bus.lcd_wr_n);
    end
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; mon_en = 1'b0; writes_seen = 0; low_len = 0;
    reset_n = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_single_cmd();
    test_burst();
    test_zero_len();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
